// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and pipeline-control unit: load-use bubbles, redirect flushes, memory wait states, debug halt.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int NUM_WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_IF,
    input  logic [4:0]  rs2_IF,
    input  logic        use_rs1_IF,
    input  logic        use_rs2_IF,
    input  logic [4:0]  rd_ID,
    input  logic        rf_wr_en_ID,
    input  logic [2:0]  dm_rd_ctrl_ID,
    input  logic        is_debug_ID,
    input  logic        redirect_EX,
    input  logic        mem_busy,
    input  logic        debug_resume,
    output logic        stall_IF,
    output logic        stall,
    output logic        stall_EXM,
    output logic        flush,
    output logic        flush_IFR,
    output logic        pc_redirect,
    output logic        mem_timeout,
    output logic [1:0]  state_o,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;

    localparam logic [16:0] WAIT_MAX = 17'(NUM_WAIT_MAX);

    state_t      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] wait_cnt_inc;
    logic        mem_timeout_q, mem_timeout_d;
    logic        lu;
    logic        run_eval;

    // Handshake note: every control output is a level valid only in the current cycle;
    // the stage registers sample them on the same rising edge, there is no ready back-pressure.

    always_comb begin
        lu = (dm_rd_ctrl_ID != 3'd0) && rf_wr_en_ID && (rd_ID != 5'd0) &&
             ((use_rs1_IF && (rs1_IF == rd_ID)) || (use_rs2_IF && (rs2_IF == rd_ID)));
    end

    // MEM_WAIT falls back to the RUN priority chain in the cycle the memory completes.
    always_comb begin
        run_eval = (state_q == ST_RUN) || ((state_q == ST_MEM_WAIT) && !mem_busy);
    end

    always_comb begin
        stall_IF    = 1'b0;
        stall       = 1'b0;
        stall_EXM   = 1'b0;
        flush       = 1'b0;
        flush_IFR   = 1'b0;
        pc_redirect = 1'b0;
        state_d     = state_q;

        case (state_q)
            ST_RUN: begin
                state_d = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    stall_IF  = 1'b1;
                    stall     = 1'b1;
                    stall_EXM = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end
            end
            ST_REDIRECT: begin
                flush_IFR = 1'b1;
                if (mem_busy) begin
                    stall_IF  = 1'b1;
                    stall     = 1'b1;
                    stall_EXM = 1'b1;
                    state_d   = ST_MEM_WAIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (mem_busy) begin
                    stall_IF  = 1'b1;
                    flush     = 1'b1;
                    stall_EXM = 1'b1;
                    state_d   = ST_HALT;
                end else if (debug_resume) begin
                    state_d = ST_RUN;
                end else begin
                    stall_IF = 1'b1;
                    flush    = 1'b1;
                    state_d  = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (run_eval) begin
            if (mem_busy) begin
                stall_IF  = 1'b1;
                stall     = 1'b1;
                stall_EXM = 1'b1;
                state_d   = ST_MEM_WAIT;
            end else if (redirect_EX) begin
                pc_redirect = 1'b1;
                flush       = 1'b1;
                flush_IFR   = 1'b1;
                state_d     = ST_REDIRECT;
            end else if (is_debug_ID) begin
                stall_IF = 1'b1;
                flush    = 1'b1;
                state_d  = ST_HALT;
            end else if (lu) begin
                stall_IF = 1'b1;
                flush    = 1'b1;
                state_d  = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end

        // Reset empties the pipe: flush both front-end registers, hold nothing.
        if (reset) begin
            stall_IF    = 1'b0;
            stall       = 1'b0;
            stall_EXM   = 1'b0;
            pc_redirect = 1'b0;
            flush       = 1'b1;
            flush_IFR   = 1'b1;
            state_d     = ST_RUN;
        end
    end

    always_comb begin
        wait_cnt_inc  = (&wait_cnt_q) ? wait_cnt_q : (wait_cnt_q + 16'd1);
        wait_cnt_d    = 16'd0;
        mem_timeout_d = mem_timeout_q;
        if (state_q == ST_MEM_WAIT) begin
            if (({1'b0, wait_cnt_q} + 17'd1) >= WAIT_MAX) begin
                mem_timeout_d = 1'b1;
            end
            if (state_d == ST_MEM_WAIT) begin
                wait_cnt_d = wait_cnt_inc;
            end
        end
        if (reset) begin
            wait_cnt_d    = 16'd0;
            mem_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q       <= state_d;
        wait_cnt_q    <= wait_cnt_d;
        mem_timeout_q <= mem_timeout_d;
    end

    assign state_o     = state_q;
    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;
    logic        lu_bubble;

    // A load-use bubble is the lowest-priority RUN action that actually fired.
    always_comb begin
        lu_bubble = run_eval && !mem_busy && !redirect_EX && !is_debug_ID && lu && !reset;
    end

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall_IF && !(&perf_stall_q)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if ((pc_redirect || lu_bubble) && !(&perf_flush_q)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
        if (reset) begin
            perf_stall_d = 32'd0;
            perf_flush_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        perf_stall_q <= perf_stall_d;
        perf_flush_q <= perf_flush_d;
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule
